// File: rtl/ahb_to_fpga_sram_pkg.sv
// Shared AHB-Lite encodings and byte-merge helper for the AHB to FPGA block-RAM bridge.
package ahb_to_fpga_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Per-byte select: buffered bytes override stale RAM bytes.
    function automatic logic [31:0] merge_bytes(input logic [3:0]  mask,
                                                input logic [31:0] buf_data,
                                                input logic [31:0] ram_data);
        logic [31:0] res;
        res = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = mask[i] ? buf_data[i*8 +: 8] : ram_data[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_sram_lane_dec.sv
// Byte-lane decoder: transfer size and low address bits to a 4-bit write/merge mask.
module ahb_sram_lane_dec
    import ahb_to_fpga_sram_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] lane_mask
);

    // Sizes above word are treated as a full word.
    always_comb begin
        lane_mask = 4'b1111;
        case (hsize)
            HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
            HSIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    end

endmodule

// File: rtl/ahb_to_fpga_sram.sv
// Zero-wait-state AHB-Lite slave for a single-port block RAM with a one-entry deferred write buffer.
module ahb_to_fpga_sram
    import ahb_to_fpga_sram_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic          HREADY,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [AW-1:0] HADDR,
    input  logic [31:0]   HWDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic [AW-3:0] SRAMADDR,
    output logic [31:0]   SRAMWDATA,
    output logic [3:0]    SRAMWEN,
    output logic          SRAMCS
);

    logic          trans_act_s;
    logic          acc_s;
    logic          rd_req_s;
    logic          wr_req_s;
    logic [3:0]    lane_s;
    logic [AW-3:0] word_addr_s;
    logic          flush_s;
    logic [3:0]    mrg_nxt_s;

    logic          wr_dp_r;
    logic [AW-3:0] wa_addr_r;
    logic [3:0]    wa_wen_r;
    logic          buf_pend_r;
    logic [AW-3:0] buf_addr_r;
    logic [3:0]    buf_wen_r;
    logic [31:0]   buf_data_r;
    logic          rd_dp_r;
    logic [3:0]    mrg_mask_r;

    assign trans_act_s = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign acc_s       = HSEL & HREADY & trans_act_s;
    assign rd_req_s    = acc_s & ~HWRITE;
    assign wr_req_s    = acc_s & HWRITE;
    assign word_addr_s = HADDR[AW-1:2];

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign SRAMWDATA = buf_data_r;

    ahb_sram_lane_dec u_lane_dec (
        .hsize     (HSIZE),
        .addr_lo   (HADDR[1:0]),
        .lane_mask (lane_s)
    );

    // RAM port arbitration: reads always win, otherwise drain the write buffer.
    always_comb begin
        SRAMCS   = 1'b0;
        SRAMADDR = buf_addr_r;
        SRAMWEN  = 4'b0000;
        flush_s  = 1'b0;
        if (!HRESETn) begin
            SRAMCS = 1'b0;
        end else if (rd_req_s) begin
            SRAMCS   = 1'b1;
            SRAMADDR = word_addr_s;
        end else if (buf_pend_r) begin
            SRAMCS  = 1'b1;
            SRAMWEN = buf_wen_r;
            flush_s = 1'b1;
        end else begin
            SRAMCS = 1'b0;
        end
    end

    // Bytes a read must take from the buffer; covers a write whose data arrives this same cycle.
    always_comb begin
        mrg_nxt_s = 4'b0000;
        if (buf_pend_r && (buf_addr_r == word_addr_s)) begin
            mrg_nxt_s = buf_wen_r;
        end else begin
            mrg_nxt_s = 4'b0000;
        end
        if (wr_dp_r && (wa_addr_r == word_addr_s)) begin
            mrg_nxt_s = mrg_nxt_s | wa_wen_r;
        end else begin
            mrg_nxt_s = mrg_nxt_s;
        end
    end

    // Read data phase output.
    always_comb begin
        HRDATA = 32'h0000_0000;
        if (rd_dp_r) begin
            HRDATA = merge_bytes(mrg_mask_r, buf_data_r, SRAMRDATA);
        end else begin
            HRDATA = 32'h0000_0000;
        end
    end

    // Address/data phase tracking and write buffer state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_dp_r    <= 1'b0;
            wa_addr_r  <= {(AW-2){1'b0}};
            wa_wen_r   <= 4'b0000;
            buf_pend_r <= 1'b0;
            buf_addr_r <= {(AW-2){1'b0}};
            buf_wen_r  <= 4'b0000;
            buf_data_r <= 32'h0000_0000;
            rd_dp_r    <= 1'b0;
            mrg_mask_r <= 4'b0000;
        end else begin
            if (wr_req_s) begin
                wa_addr_r <= word_addr_s;
                wa_wen_r  <= lane_s;
                wr_dp_r   <= 1'b1;
            end else if (HREADY) begin
                wr_dp_r <= 1'b0;
            end

            // A load on the same edge as a flush keeps the new write pending.
            if (wr_dp_r && HREADY) begin
                buf_addr_r <= wa_addr_r;
                buf_wen_r  <= wa_wen_r;
                buf_data_r <= HWDATA;
                buf_pend_r <= 1'b1;
            end else if (flush_s) begin
                buf_pend_r <= 1'b0;
            end

            if (rd_req_s) begin
                rd_dp_r    <= 1'b1;
                mrg_mask_r <= mrg_nxt_s;
            end else if (HREADY) begin
                rd_dp_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_to_fpga_sram.sv
// Directed bench for ahb_to_fpga_sram with a 1-cycle registered-read byte-write RAM model.
module tb_ahb_to_fpga_sram;
    import ahb_to_fpga_sram_pkg::*;

    localparam int AW = 16;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL, HREADY, HWRITE;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [AW-1:0] HADDR;
    logic [31:0]   HWDATA;
    logic          HREADYOUT, HRESP;
    logic [31:0]   HRDATA;
    logic [31:0]   SRAMRDATA;
    logic [AW-3:0] SRAMADDR;
    logic [31:0]   SRAMWDATA;
    logic [3:0]    SRAMWEN;
    logic          SRAMCS;

    logic [31:0] mem [0:(1<<(AW-2))-1];
    logic [31:0] exp_q [$];
    logic [31:0] wdata_nxt;
    logic        chk_nxt;
    int          n_tests = 0;
    int          n_fail  = 0;

    ahb_to_fpga_sram #(.AW(AW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR),
        .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .SRAMRDATA(SRAMRDATA), .SRAMADDR(SRAMADDR), .SRAMWDATA(SRAMWDATA),
        .SRAMWEN(SRAMWEN), .SRAMCS(SRAMCS)
    );

    always #5 HCLK = ~HCLK;

    // RAM model: read returns pre-write contents one cycle later.
    always @(posedge HCLK) begin
        if (SRAMCS) begin
            SRAMRDATA <= mem[SRAMADDR];
            for (int b = 0; b < 4; b++) begin
                if (SRAMWEN[b]) mem[SRAMADDR][b*8 +: 8] = SRAMWDATA[b*8 +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle; returns at the falling edge so the caller can inspect the RAM port.
    task automatic step(input logic sel, input logic rdy, input logic [1:0] trans,
                        input logic wr, input logic [2:0] size, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic has_exp, input logic [31:0] exp_rd);
        logic cur_chk;
        logic acc;
        logic [31:0] e;
        @(posedge HCLK); #1;
        HWDATA  = wdata_nxt;
        cur_chk = chk_nxt;
        HSEL = sel; HREADY = rdy; HTRANS = trans; HWRITE = wr; HSIZE = size; HADDR = addr;
        acc       = sel & rdy & trans[1];
        wdata_nxt = (acc && wr) ? wdata : 32'h0;
        chk_nxt   = acc && !wr && has_exp;
        if (chk_nxt) exp_q.push_back(exp_rd);
        @(negedge HCLK);
        chk("hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("hresp", {31'h0, HRESP}, 32'h0);
        if (cur_chk) begin
            e = exp_q.pop_front();
            chk("hrdata", HRDATA, e);
        end else begin
            chk("hrdata_idle", HRDATA, 32'h0);
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b1, HTRANS_IDLE, 1'b0, HSIZE_WORD, 16'h0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic wr(input logic [2:0] size, input logic [15:0] addr, input logic [31:0] d);
        step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b1, size, addr, d, 1'b0, 32'h0);
    endtask

    task automatic rd(input logic [15:0] addr, input logic [31:0] e);
        step(1'b1, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, addr, 32'h0, 1'b1, e);
    endtask

    task automatic chk_port(input string tag, input logic cs, input logic [3:0] wen, input logic [13:0] a);
        chk({tag, "_cs"}, {31'h0, SRAMCS}, {31'h0, cs});
        chk({tag, "_wen"}, {28'h0, SRAMWEN}, {28'h0, wen});
        if (cs) chk({tag, "_addr"}, {18'h0, SRAMADDR}, {18'h0, a});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << (AW-2)); i++) mem[i] = 32'h0;
        wdata_nxt = 32'h0; chk_nxt = 1'b0; HWDATA = 32'h0;
        // Reset with a read request on the bus: RAM must stay quiet.
        HRESETn = 1'b0;
        HSEL = 1'b1; HREADY = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = 1'b0;
        HSIZE = HSIZE_WORD; HADDR = 16'h0010;
        #12;
        chk_port("rst", 1'b0, 4'h0, 14'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("rst_hresp", {31'h0, HRESP}, 32'h0);
        HTRANS = HTRANS_IDLE;
        @(negedge HCLK); HRESETn = 1'b1;

        // 1: word write then idle drains to word 4
        wr(HSIZE_WORD, 16'h0010, 32'hDEADBEEF);
        idle();
        chk_port("t1_dp", 1'b0, 4'h0, 14'h0);
        idle();
        chk_port("t1_flush", 1'b1, 4'hF, 14'h004);
        chk("t1_wdata", SRAMWDATA, 32'hDEADBEEF);
        rd(16'h0010, 32'hDEADBEEF);
        idle();

        // 2: byte write merged into an immediate read of the same word
        mem[4] = 32'h11223344;
        wr(HSIZE_BYTE, 16'h0013, 32'hAB000000);
        rd(16'h0010, 32'hAB223344);
        chk_port("t2_rd", 1'b1, 4'h0, 14'h004);
        idle();
        chk_port("t2_flush", 1'b1, 4'h8, 14'h004);
        chk("t2_mem_before", mem[4], 32'h11223344);
        idle();
        chk("t2_mem_after", mem[4], 32'hAB223344);

        // 3: back-to-back half-word writes
        wr(HSIZE_HALF, 16'h0020, 32'h00005566);
        wr(HSIZE_HALF, 16'h0022, 32'h77880000);
        idle();
        chk_port("t3_flush0", 1'b1, 4'h3, 14'h008);
        idle();
        chk_port("t3_flush1", 1'b1, 4'hC, 14'h008);
        rd(16'h0020, 32'h77885566);
        idle();

        // 4: oversized HSIZE acts as word; buffer held across consecutive reads
        mem[13] = 32'hCAFEF00D;
        wr(3'b011, 16'h0030, 32'h12345678);
        rd(16'h0030, 32'h12345678);
        chk_port("t4_r0", 1'b1, 4'h0, 14'h00C);
        rd(16'h0034, 32'hCAFEF00D);
        chk_port("t4_r1", 1'b1, 4'h0, 14'h00D);
        rd(16'h0030, 32'h12345678);
        chk_port("t4_r2", 1'b1, 4'h0, 14'h00C);
        rd(16'h0034, 32'hCAFEF00D);
        rd(16'h0030, 32'h12345678);
        chk_port("t4_r4", 1'b1, 4'h0, 14'h00C);
        chk("t4_mem_held", mem[12], 32'h0);
        idle();
        chk_port("t4_flush", 1'b1, 4'hF, 14'h00C);
        idle();
        chk("t4_mem_after", mem[12], 32'h12345678);

        // 5: NONSEQ not accepted when HREADY=0 or HSEL=0
        step(1'b1, 1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0040, 32'h5555AAAA, 1'b0, 32'h0);
        chk_port("t5_nordy", 1'b0, 4'h0, 14'h0);
        step(1'b0, 1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 16'h0040, 32'h0, 1'b0, 32'h0);
        chk_port("t5_nosel", 1'b0, 4'h0, 14'h0);
        step(1'b0, 1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 16'h0040, 32'h5555AAAA, 1'b0, 32'h0);
        idle();
        chk_port("t5_nobuf", 1'b0, 4'h0, 14'h0);
        chk("t5_mem", mem[16], 32'h0);

        // 6: reset discards a pending buffered write
        mem[20] = 32'h0BADC0DE;
        wr(HSIZE_WORD, 16'h0050, 32'h99999999);
        idle();
        idle();
        chk_port("t6_pend", 1'b1, 4'hF, 14'h014);
        #1 HRESETn = 1'b0;
        #1;
        chk_port("t6_rst", 1'b0, 4'h0, 14'h0);
        chk("t6_rst_hrdata", HRDATA, 32'h0);
        @(posedge HCLK);
        @(negedge HCLK); HRESETn = 1'b1;
        wdata_nxt = 32'h0; chk_nxt = 1'b0;
        chk("t6_mem_kept", mem[20], 32'h0BADC0DE);
        rd(16'h0050, 32'h0BADC0DE);
        idle();
        idle();
        chk("t6_mem_final", mem[20], 32'h0BADC0DE);
        chk("sb_empty", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
